// File: rtl/scan_display_ctrl_pkg.sv
// Widths and seven-segment codes shared by the display scanner and its decoder.
// Segment codes are active-low with the decimal point (bit 7) off.
package scan_display_ctrl_pkg;

  localparam int BCD_BIT_WIDTH = 4;
  localparam int SSD_BIT_WIDTH = 8;
  localparam int SSD_DIGIT_NUM = 4;

  localparam logic [SSD_BIT_WIDTH-1:0] SS_0     = 8'hC0;
  localparam logic [SSD_BIT_WIDTH-1:0] SS_1     = 8'hF9;
  localparam logic [SSD_BIT_WIDTH-1:0] SS_2     = 8'hA4;
  localparam logic [SSD_BIT_WIDTH-1:0] SS_3     = 8'hB0;
  localparam logic [SSD_BIT_WIDTH-1:0] SS_4     = 8'h99;
  localparam logic [SSD_BIT_WIDTH-1:0] SS_5     = 8'h92;
  localparam logic [SSD_BIT_WIDTH-1:0] SS_6     = 8'h82;
  localparam logic [SSD_BIT_WIDTH-1:0] SS_7     = 8'hF8;
  localparam logic [SSD_BIT_WIDTH-1:0] SS_8     = 8'h80;
  localparam logic [SSD_BIT_WIDTH-1:0] SS_9     = 8'h90;
  localparam logic [SSD_BIT_WIDTH-1:0] SS_DASH  = 8'hBF;
  localparam logic [SSD_BIT_WIDTH-1:0] SS_BLANK = 8'hFF;

  localparam logic [SSD_DIGIT_NUM-1:0] SSD_CTL_OFF = 4'b1111;

endpackage

// File: rtl/scan_display_ctrl_bcd_to_ssd.sv
// Combinational BCD to active-low g..a segment decoder; codes 10..15 show a dash.
module bcd_to_ssd
  import scan_display_ctrl_pkg::*;
(
  input  logic [BCD_BIT_WIDTH-1:0] bcd,
  output logic [6:0]               seg
);

  always_comb begin
    seg = SS_DASH[6:0];
    case (bcd)
      4'd0: seg = SS_0[6:0];
      4'd1: seg = SS_1[6:0];
      4'd2: seg = SS_2[6:0];
      4'd3: seg = SS_3[6:0];
      4'd4: seg = SS_4[6:0];
      4'd5: seg = SS_5[6:0];
      4'd6: seg = SS_6[6:0];
      4'd7: seg = SS_7[6:0];
      4'd8: seg = SS_8[6:0];
      4'd9: seg = SS_9[6:0];
      default: seg = SS_DASH[6:0];
    endcase
  end

endmodule

// File: rtl/scan_display_ctrl.sv
// Time-multiplexes four BCD digits onto a common-anode 4-digit display with
// leading-zero blanking, per-digit blinking and decimal points; outputs registered.
module scan_display_ctrl
  import scan_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int SCAN_CNT_WIDTH  = 17,
  parameter int BLINK_DIV       = 25000000,
  parameter int BLINK_CNT_WIDTH = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BCD_BIT_WIDTH-1:0] digit3,
  input  logic [BCD_BIT_WIDTH-1:0] digit2,
  input  logic [BCD_BIT_WIDTH-1:0] digit1,
  input  logic [BCD_BIT_WIDTH-1:0] digit0,
  input  logic                     blank_lead,
  input  logic [SSD_DIGIT_NUM-1:0] blink_mask,
  input  logic [SSD_DIGIT_NUM-1:0] dot_mask,
  output logic [SSD_DIGIT_NUM-1:0] ssd_ctl,
  output logic [SSD_BIT_WIDTH-1:0] ssd_seg,
  output logic [1:0]               scan_idx
);

  logic [SCAN_CNT_WIDTH-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]                 scan_idx_q, scan_idx_d;
  logic [BLINK_CNT_WIDTH-1:0] blink_cnt_q, blink_cnt_d;
  logic                       blink_phase_q, blink_phase_d;
  logic [SSD_DIGIT_NUM-1:0]   ssd_ctl_q, ssd_ctl_d;
  logic [SSD_BIT_WIDTH-1:0]   ssd_seg_q, ssd_seg_d;

  logic [BCD_BIT_WIDTH-1:0] digit_sel;
  logic [SSD_DIGIT_NUM-1:0] lead_blank;
  logic                     blank_sel;
  logic [6:0]               seg_code;

  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    scan_idx_d  = scan_idx_q;
    if (scan_cnt_q == SCAN_CNT_WIDTH'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = scan_idx_q + 2'd1;
    end
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_CNT_WIDTH'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Only the two leftmost digits may be suppressed as leading zeros.
  assign lead_blank = {blank_lead && (digit3 == '0),
                       blank_lead && (digit3 == '0) && (digit2 == '0),
                       2'b00};

  always_comb begin
    digit_sel = digit0;
    case (scan_idx_q)
      2'd0: digit_sel = digit0;
      2'd1: digit_sel = digit1;
      2'd2: digit_sel = digit2;
      2'd3: digit_sel = digit3;
      default: digit_sel = digit0;
    endcase
  end

  assign blank_sel = (blink_mask[scan_idx_q] && !blink_phase_q) || lead_blank[scan_idx_q];

  bcd_to_ssd u_bcd_to_ssd (
    .bcd (digit_sel),
    .seg (seg_code)
  );

  // The enable stays low even for a blanked digit so duty cycle is constant.
  always_comb begin
    ssd_ctl_d = ~(SSD_DIGIT_NUM'(1) << scan_idx_q);
    ssd_seg_d = blank_sel ? SS_BLANK : {~dot_mask[scan_idx_q], seg_code};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_q    <= '0;
      scan_idx_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      ssd_ctl_q     <= SSD_CTL_OFF;
      ssd_seg_q     <= SS_BLANK;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      scan_idx_q    <= scan_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      ssd_ctl_q     <= ssd_ctl_d;
      ssd_seg_q     <= ssd_seg_d;
    end
  end

  assign ssd_ctl  = ssd_ctl_q;
  assign ssd_seg  = ssd_seg_q;
  assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Self-checking bench for scan_display_ctrl: directed plan steps then random
// stimulus, compared against a cycle-count based reference model.
module tb_scan_display_ctrl;

  localparam int SD = 4;
  localparam int BD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dig [4];
  logic       blank_lead;
  logic [3:0] blink_mask;
  logic [3:0] dot_mask;
  logic [3:0] ssd_ctl;
  logic [7:0] ssd_seg;
  logic [1:0] scan_idx;

  int checks = 0;
  int errors = 0;
  int k = 0;  // number of non-reset edges since the last reset

  always #5 clk = ~clk;

  scan_display_ctrl #(
    .SCAN_DIV        (SD),
    .SCAN_CNT_WIDTH  (3),
    .BLINK_DIV       (BD),
    .BLINK_CNT_WIDTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit3     (dig[3]),
    .digit2     (dig[2]),
    .digit1     (dig[1]),
    .digit0     (dig[0]),
    .blank_lead (blank_lead),
    .blink_mask (blink_mask),
    .dot_mask   (dot_mask),
    .ssd_ctl    (ssd_ctl),
    .ssd_seg    (ssd_seg),
    .scan_idx   (scan_idx)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input int idx, input bit visible);
    bit blank;
    blank = (blink_mask[idx] && !visible);
    if (blank_lead && dig[3] == 0 && idx == 3) blank = 1;
    if (blank_lead && dig[3] == 0 && dig[2] == 0 && idx == 2) blank = 1;
    if (blank) return 8'hFF;
    return {~dot_mask[idx], seg_of(dig[idx])};
  endfunction

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Predict from the inputs present at the coming edge, clock it, then compare.
  task automatic step();
    logic [3:0] e_ctl;
    logic [7:0] e_seg;
    logic [3:0] e_idx;
    int idx;
    bit vis;
    if (!rst_n) begin
      e_ctl = 4'hF; e_seg = 8'hFF; e_idx = 0;
    end else begin
      idx   = (k / SD) % 4;
      vis   = ((k / BD) % 2) == 0;
      e_ctl = 4'hF & ~(4'b0001 << idx);
      e_seg = model_seg(idx, vis);
      e_idx = 4'(((k + 1) / SD) % 4);
    end
    @(posedge clk);
    #1;
    k = rst_n ? k + 1 : 0;
    $display("k=%0d rst_n=%b ctl=%b seg=%h idx=%0d", k, rst_n, ssd_ctl, ssd_seg, scan_idx);
    check4("ssd_ctl", ssd_ctl, e_ctl);
    check8("ssd_seg", ssd_seg, e_seg);
    check4("scan_idx", {2'b00, scan_idx}, e_idx);
  endtask

  task automatic set_digits(input logic [3:0] a3, input logic [3:0] a2,
                            input logic [3:0] a1, input logic [3:0] a0);
    dig[3] = a3; dig[2] = a2; dig[1] = a1; dig[0] = a0;
  endtask

  initial begin
    rst_n = 1'b0;
    set_digits(4'd1, 4'd2, 4'd5, 4'd9);
    blank_lead = 1'b0; blink_mask = 4'b0; dot_mask = 4'b0;

    repeat (3) step();
    check4("reset_ctl_const", ssd_ctl, 4'b1111);
    check8("reset_seg_const", ssd_seg, 8'hFF);

    rst_n = 1'b1;
    step();
    check4("first_ctl_const", ssd_ctl, 4'b1110);
    check8("first_seg_const", ssd_seg, 8'h90);
    repeat (16) step();

    dig[0] = 4'hC;
    repeat (8) step();

    blank_lead = 1'b1;
    set_digits(4'd0, 4'd0, 4'd0, 4'd7);
    repeat (16) step();
    set_digits(4'd0, 4'd5, 4'd0, 4'd0);
    repeat (16) step();
    blank_lead = 1'b0;
    repeat (16) step();

    set_digits(4'd8, 4'd8, 4'd8, 4'd8);
    blink_mask = 4'b0011; dot_mask = 4'b0100;
    repeat (40) step();

    // Reset while digit2 is selected and blinking digits are hidden.
    for (int n = 0; n < 64; n++) begin
      if (((k / SD) % 4) == 2 && ((k / BD) % 2) == 1) break;
      step();
    end
    checks++;
    assert (((k / SD) % 4) == 2 && ((k / BD) % 2) == 1) else begin
      errors++;
      $error("FAIL midreset_setup k=%0d observed=not_reached expected=idx2_phase0", k);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (20) step();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0)
        set_digits(4'($urandom_range(15)), 4'($urandom_range(15)),
                   4'($urandom_range(15)), 4'($urandom_range(15)));
      if ($urandom_range(7) == 0) begin
        blank_lead = 1'($urandom_range(1));
        blink_mask = 4'($urandom_range(15));
        dot_mask   = 4'($urandom_range(15));
      end
      if ($urandom_range(15) == 0) begin
        dig[3] = 4'd0;
        if ($urandom_range(1) == 0) dig[2] = 4'd0;
      end
      rst_n = ($urandom_range(59) != 0);
      step();
    end
    rst_n = 1'b1;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_display_ctrl.md
Name: scan_display_ctrl

Overview:
Downstream consumer of the BCD digit counters in the clock datapath. Takes four BCD digits (e.g. min tens/ones, sec tens/ones) and time-multiplexes them onto a 4-digit common-anode seven-segment display. Also handles leading-zero blanking, per-digit blinking (setting mode) and decimal points. All outputs are registered.

Parameters:
SCAN_DIV, 100000, clock cycles each digit stays selected (1 kHz per digit at 100 MHz)
SCAN_CNT_WIDTH, 17, width of scan divider counter; must satisfy 2^SCAN_CNT_WIDTH >= SCAN_DIV
BLINK_DIV, 25000000, clock cycles per blink half-period (2 Hz blink at 100 MHz)
BLINK_CNT_WIDTH, 25, width of blink counter; must satisfy 2^BLINK_CNT_WIDTH >= BLINK_DIV

Ports:
clk  input  1  system clock; single clock domain
rst_n  input  1  reset, synchronous, active-low
digit3  input  `BCD_BIT_WIDTH  leftmost BCD digit (from counter q)
digit2  input  `BCD_BIT_WIDTH  BCD digit
digit1  input  `BCD_BIT_WIDTH  BCD digit
digit0  input  `BCD_BIT_WIDTH  rightmost BCD digit
blank_lead  input  1  enable leading-zero blanking on digit3/digit2
blink_mask  input  4  bit i=1: digit i blinks
dot_mask  input  4  bit i=1: decimal point of digit i lit
ssd_ctl  output  4  digit enables, active-low, one-hot-low; bit i = digit i
ssd_seg  output  8  segments, active-low; bit7=dp, bit6..0=g,f,e,d,c,b,a
scan_idx  output  2  currently selected digit (debug/verification)

Behaviour:
- Reset: rst_n sampled low at a clk edge sets scan_cnt=0, scan_idx=0, blink_cnt=0, blink_phase=1 (visible), ssd_ctl=4'b1111, ssd_seg=8'hFF. This is synchronous only; rst_n has no effect between edges. Reset mid-scan or mid-blink restarts both counters from zero.
- Scan divider: scan_cnt increments each cycle. When scan_cnt==SCAN_DIV-1 it wraps to 0 and scan_idx advances by 1 mod 4 (3->0). With SCAN_DIV=1, scan_idx advances every cycle.
- Blink divider: blink_cnt increments each cycle. When blink_cnt==BLINK_DIV-1 it wraps to 0 and blink_phase toggles. Free-running; not affected by blink_mask changes.
- Output register: every cycle, ssd_ctl/ssd_seg are loaded from the current (pre-edge) scan_idx and the current input values. Latency is 1 cycle from any input or scan_idx change to the outputs. The first cycle after reset release drives digit0 (ssd_ctl=4'b1110).
- ssd_ctl = ~(4'b0001 << scan_idx). It is always one digit low outside reset, including when the digit is blanked, which keeps brightness duty constant.
- Digit i is blanked when either condition holds:
  - blink_mask[i]==1 and blink_phase==0
  - leading-zero rule: blank_lead==1 and digit3==0 blanks digit3; blank_lead==1 and digit3==0 and digit2==0 blanks digit2. digit1/digit0 are never leading-zero blanked.
- Blanked digit: ssd_seg=8'hFF, dp forced off.
- Segment codes bit6..0 (g..a, active-low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - invalid BCD 10..15 = dash 7'h3F
- ssd_seg[7] = ~dot_mask[scan_idx] when the digit is not blanked.
- Inputs are treated as synchronous to clk and may change on any cycle. No handshake; the display reflects whatever is present one cycle later.

Decomposition:
- global.v gains:
  - `SSD_BIT_WIDTH (8)
  - `SSD_DIGIT_NUM (4)
  - segment code macros `SS_0..`SS_9, `SS_DASH, `SS_BLANK (8'hFF)
  - `SSD_CTL_OFF (4'b1111)
- Existing `BCD_BIT_WIDTH, `ENABLED/`DISABLED and `ONE are reused.
- One combinational sub-module: bcd_to_ssd (BCD in, 7-bit segment code out, dash for invalid). It is instantiated once on the muxed digit.

Test Plan:
- Run the bench with SCAN_DIV=4, BLINK_DIV=8.
- Reset/scan: hold rst_n=0 for 3 cycles -> ssd_ctl=4'b1111, ssd_seg=8'hFF. Release -> next cycle ssd_ctl=4'b1110. ssd_ctl then steps 1101, 1011, 0111, 1110 every 4 cycles.
- Decode: digits 3,2,1,0 = 1,2,5,9, masks 0 -> ssd_seg = 8'hF9, 8'hA4, 8'h92, 8'h90 in the respective slots. Setting digit0 to 4'hC -> 8'hBF.
- Leading zero: digits 0,0,0,7 with blank_lead=1 -> digit3 and digit2 slots 8'hFF, digit1 slot 8'hC0, digit0 slot 8'hF8. digits 0,5,0,0 -> only digit3 blanked. blank_lead=0 -> all drawn.
- Blink/dot: blink_mask=4'b0011, dot_mask=4'b0100, digits all 8 -> digit1/digit0 slots alternate 8'h80 and 8'hFF every 8 cycles. digit2 slot is constantly 8'h00 (dp on). digit3 slot is constantly 8'h80.
- Mid-operation reset: assert rst_n=0 for one cycle while scan_idx=2 and blink_phase=0 -> next cycle outputs off. After release the sequence restarts at digit0, and blinking digits are visible for the first 8 cycles.
